// File: rtl/cpu_completion_monitor.sv
// cpu_completion_monitor: end-of-program monitor downstream of the cpu top.
// Folds every data-memory store into a rotate-xor signature, counts stores and
// cycles, and declares pass/fail once pc parks on FINISH_PC, or timeout.
// Optional store log: define CPU_COMPLETION_MON_STORE_LOG_EN (LOG_DEPTH >= 2).
module cpu_completion_monitor #(
  parameter logic [31:0] FINISH_PC     = 32'h0000_0054,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned MAX_CYCLES    = 400,
  parameter logic [31:0] EXP_SIGNATURE = 32'h0,
  parameter int unsigned EXP_STORES    = 8,
  parameter int unsigned LOG_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [2:0]  state_o,
  output logic [31:0] signature_o,
  output logic [15:0] store_cnt_o,
  output logic [31:0] cycle_cnt_o
`ifdef CPU_COMPLETION_MON_STORE_LOG_EN
  ,
  input  logic [$clog2(LOG_DEPTH)-1:0] log_idx_i,
  output logic [63:0]                  log_data_o
`endif
);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_SETTLE = 3'd1,
    S_PASS   = 3'd2,
    S_FAIL   = 3'd3,
    S_TMO    = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_sig, w_sig_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_cycle, w_cycle_nxt;
  logic [31:0] r_stable, w_stable_nxt;
  logic        r_done, r_pass, r_tmo;
  logic        w_active, w_store, w_at_finish, w_complete, w_timeout, w_match;

  // Next-state, signature fold and counter updates; completion beats timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_stable_nxt = r_stable;
    w_active     = (r_state == S_RUN) || (r_state == S_SETTLE);
    w_store      = w_active && mem_we_i;
    w_at_finish  = (pc_i == FINISH_PC);
    w_sig_nxt    = w_store ? ({r_sig[30:0], r_sig[31]} ^ mem_addr_i ^ mem_wdata_i) : r_sig;
    w_cnt_nxt    = (w_store && r_cnt != 16'hFFFF) ? r_cnt + 16'd1 : r_cnt;
    w_cycle_nxt  = (w_active && r_cycle != 32'hFFFF_FFFF) ? r_cycle + 32'd1 : r_cycle;
    case (r_state)
      S_RUN: begin
        if (w_at_finish) begin
          w_stable_nxt = 32'd1;
          w_state_nxt  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_at_finish) begin
          w_stable_nxt = r_stable + 32'd1;
        end else begin
          w_stable_nxt = 32'd0;
          w_state_nxt  = S_RUN;
        end
      end
      default: ;
    endcase
    // The store of the completing cycle is already in w_sig_nxt / w_cnt_nxt.
    w_complete = w_active && w_at_finish && (w_stable_nxt >= 32'(STABLE_CYCLES));
    w_timeout  = w_active && ((r_cycle + 32'd1) == 32'(MAX_CYCLES));
    w_match    = (w_sig_nxt == EXP_SIGNATURE) && (w_cnt_nxt == 16'(EXP_STORES));
    if (w_complete)
      w_state_nxt = w_match ? S_PASS : S_FAIL;
    else if (w_timeout)
      w_state_nxt = S_TMO;
  end

  // State register plus registered status flags; terminal states freeze all.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= S_RUN;
      r_sig    <= '0;
      r_cnt    <= '0;
      r_cycle  <= '0;
      r_stable <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sig    <= w_sig_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cycle  <= w_cycle_nxt;
      r_stable <= w_stable_nxt;
      r_done   <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL) || (w_state_nxt == S_TMO);
      r_pass   <= (w_state_nxt == S_PASS);
      r_tmo    <= (w_state_nxt == S_TMO);
    end
  end

  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign timeout_o   = r_tmo;
  assign state_o     = r_state;
  assign signature_o = r_sig;
  assign store_cnt_o = r_cnt;
  assign cycle_cnt_o = r_cycle;

`ifdef CPU_COMPLETION_MON_STORE_LOG_EN
  localparam int unsigned LOG_AW = $clog2(LOG_DEPTH);

  logic [63:0]       r_log [LOG_DEPTH];
  logic [LOG_AW-1:0] r_wptr;
  logic [63:0]       r_log_data;
  logic [LOG_AW-1:0] w_rd_idx;

  // idx 0 is the entry just behind the write pointer (most recent store).
  assign w_rd_idx = r_wptr - LOG_AW'(1) - log_idx_i;

  // Circular store log; pointer wraps and overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < int'(LOG_DEPTH); i++) r_log[i] <= '0;
      r_wptr     <= '0;
      r_log_data <= '0;
    end else begin
      if (w_store) begin
        r_log[r_wptr] <= {mem_addr_i, mem_wdata_i};
        r_wptr        <= r_wptr + LOG_AW'(1);
      end
      r_log_data <= r_log[w_rd_idx];
    end
  end

  assign log_data_o = r_log_data;
`endif

endmodule
